log2_block_max_abs: RTL and testbench

Streaming shared-exponent finder for MXINT quantisation. It takes a block of `NUM_BEATS` beats, each beat carrying `IN_SIZE` lanes. Each lane's magnitude is OR-accumulated across the whole block, and the block emits one exponent: the highest set bit position plus one, or 0 for an all-zero block. It sits ahead of the MXINT mantissa shifter and replaces single-beat exponent extraction when a block spans several bus beats.

---
 rtl/mxint_pkg.sv | 22 ++
 rtl/lane_abs_or.sv | 33 +++
 rtl/log2_block_max_abs.sv | 96 +++++++++
 tb/tb_log2_block_max_abs.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// rtl/mxint_pkg.sv - shared widths, helpers and types for the MXINT exponent finder
package mxint_pkg;

  function automatic int exp_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // A one-beat block still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IN_WIDTH = 16;

  typedef logic [$clog2(DEFAULT_IN_WIDTH):0] exp_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/lane_abs_or.sv
// rtl/lane_abs_or.sv - per-lane magnitude and OR-reduce of one beat
// LOG2_BLOCK_MAX_ABS_SAT_EN saturates the most-negative signed lane instead of wrapping.
module lane_abs_or #(
  parameter int IN_SIZE  = 4,
  parameter int IN_WIDTH = 16,
  parameter int SIGNED   = 1
) (
  input  logic [IN_WIDTH-1:0] data_in [IN_SIZE],
  output logic [IN_WIDTH-1:0] beat_or
);

  localparam logic [IN_WIDTH-1:0] ONE      = IN_WIDTH'(1);
  localparam logic [IN_WIDTH-1:0] MOST_NEG = {1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic [IN_WIDTH-1:0] MAX_POS  = {1'b0, {(IN_WIDTH-1){1'b1}}};

  logic [IN_WIDTH-1:0] w_mag;

  always_comb begin
    beat_or = '0;
    w_mag   = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      w_mag = data_in[i];
      if ((SIGNED != 0) && data_in[i][IN_WIDTH-1]) begin
        w_mag = ~data_in[i] + ONE;
`ifdef LOG2_BLOCK_MAX_ABS_SAT_EN
        if (data_in[i] == MOST_NEG) w_mag = MAX_POS;
`endif
      end
      beat_or = beat_or | w_mag;
    end
  end

endmodule

// File: rtl/log2_block_max_abs.sv
// rtl/log2_block_max_abs.sv - multi-beat shared-exponent finder for MXINT blocks
// Optional LOG2_BLOCK_MAX_ABS_SAT_EN is handled in lane_abs_or.
module log2_block_max_abs
  import mxint_pkg::*;
#(
  parameter int IN_SIZE   = 4,
  parameter int IN_WIDTH  = 16,
  parameter int NUM_BEATS = 4,
  parameter int SIGNED    = 1,
  parameter int OUT_WIDTH = exp_width(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_out_zero,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int CW = cnt_width(NUM_BEATS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

  logic [IN_WIDTH-1:0]  r_acc;
  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_data_out;
  logic                 r_zero;
  out_state_t           r_state;
  out_state_t           w_state_nxt;

  logic [IN_WIDTH-1:0]  w_beat_or;
  logic [IN_WIDTH-1:0]  w_final;
  logic [OUT_WIDTH-1:0] w_exp;
  logic                 w_last;
  logic                 w_in_fire;
  logic                 w_out_fire;

  lane_abs_or #(
    .IN_SIZE  (IN_SIZE),
    .IN_WIDTH (IN_WIDTH),
    .SIGNED   (SIGNED)
  ) u_lane_abs_or (
    .data_in (data_in),
    .beat_or (w_beat_or)
  );

  assign w_final        = r_acc | w_beat_or;
  assign w_last         = (r_cnt == LAST);
  assign data_out_valid = (r_state == OUT_FULL);
  // Only the closing beat needs a free output slot, so partial beats never stall.
  assign data_in_ready  = !w_last || !data_out_valid || data_out_ready;
  assign w_in_fire      = data_in_valid && data_in_ready;
  assign w_out_fire     = data_out_valid && data_out_ready;
  assign data_out       = r_data_out;
  assign data_out_zero  = r_zero;

  always_comb begin
    w_exp = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (w_final[i]) w_exp = OUT_WIDTH'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_zero     <= 1'b0;
    end else if (w_in_fire) begin
      if (w_last) begin
        r_data_out <= w_exp;
        r_zero     <= (w_final == '0);
        r_acc      <= '0;
        r_cnt      <= '0;
      end else begin
        r_acc <= w_final;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= OUT_EMPTY;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_in_fire && w_last) w_state_nxt = OUT_FULL;
    else if (w_out_fire)     w_state_nxt = OUT_EMPTY;
  end

endmodule

// File: tb/tb_log2_block_max_abs.sv
// tb/tb_log2_block_max_abs.sv - self-checking bench for log2_block_max_abs (IN_SIZE=2, IN_WIDTH=8, NUM_BEATS=4)
module tb_log2_block_max_abs;

  localparam int IN_SIZE = 2;
  localparam int IN_WIDTH = 8;
  localparam int NUM_BEATS = 4;
  localparam int OW = 4;
`ifdef LOG2_BLOCK_MAX_ABS_SAT_EN
  localparam int EXP_MIN_NEG = 7;
`else
  localparam int EXP_MIN_NEG = 8;
`endif

  typedef struct {
    logic [7:0] d [8];
    int         exp;
    bit         zero;
  } vec_t;

  typedef struct {
    int exp;
    bit zero;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    din [IN_SIZE];
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [OW-1:0] dout;
  logic          dout_zero;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t exp_q [$];
  int   pop_cyc [$];
  vec_t vecs [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  log2_block_max_abs #(
    .IN_SIZE   (IN_SIZE),
    .IN_WIDTH  (IN_WIDTH),
    .NUM_BEATS (NUM_BEATS),
    .SIGNED    (1),
    .OUT_WIDTH (OW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_in_valid  (din_valid),
    .data_in_ready  (din_ready),
    .data_out       (dout),
    .data_out_zero  (dout_zero),
    .data_out_valid (dout_valid),
    .data_out_ready (dout_ready)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Output monitor; inputs only change just after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", dout);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("data_out", int'(dout), r.exp);
        chk("data_out_zero", int'(dout_zero), int'(r.zero));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, output int waits);
    bit rdy;
    waits = 0;
    din[0] = a;
    din[1] = b;
    din_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 40) begin
        chk("send_timeout", waits, 0);
        break;
      end
    end
  endtask

  task automatic send_block(input vec_t v, output int waits);
    int w;
    res_t r;
    waits = 0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (k == NUM_BEATS - 1) begin
        r.exp = v.exp;
        r.zero = v.zero;
        exp_q.push_back(r);
      end
      send_beat(v.d[2*k], v.d[2*k+1], w);
      waits += w;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    vec_t v;

    vecs[0].d = '{8'h04, 8'h00, 8'h00, 8'hFD, 8'h01, 8'h00, 8'h00, 8'h00}; vecs[0].exp = 3; vecs[0].zero = 0;
    vecs[1].d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[1].exp = 0; vecs[1].zero = 1;
    vecs[2].d = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].exp = EXP_MIN_NEG; vecs[2].zero = 0;
    vecs[3].d = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[3].exp = 7; vecs[3].zero = 0;
    vecs[4].d = '{8'h10, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[4].exp = 6; vecs[4].zero = 0;
    vecs[5].d = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01}; vecs[5].exp = 1; vecs[5].zero = 0;
    vecs[6].d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02}; vecs[6].exp = 2; vecs[6].zero = 0;
    vecs[7].d = '{8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[7].exp = 7; vecs[7].zero = 0;
    din[0] = '0;
    din[1] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_data_out", int'(dout), 0);
    chk("reset_zero", int'(dout_zero), 0);
    chk("reset_in_ready", int'(din_ready), 1);
    @(posedge clk);
    #1 dout_ready = 1'b1;

    // Table-driven blocks; the first one is followed by an idle gap to see a one-cycle valid pulse.
    for (int i = 0; i < 8; i++) begin
      send_block(vecs[i], w);
      chk("table_no_stall", w, 0);
      if (i == 0) begin
        din_valid = 1'b0;
        @(negedge clk);
        chk("pulse_valid_hi", int'(dout_valid), 1);
        @(negedge clk);
        chk("pulse_valid_lo", int'(dout_valid), 0);
        @(posedge clk);
        #1;
      end
    end
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Hold the result and let the next block's final beat stall.
    dout_ready = 1'b0;
    v.d = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00}; v.exp = 1; v.zero = 0;
    send_block(v, w);
    chk("stall_a_waits", w, 0);
    v.d = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; v.exp = 6; v.zero = 0;
    for (int k = 0; k < 3; k++) begin
      send_beat(v.d[2*k], v.d[2*k+1], w);
      chk("stall_b_partial_waits", w, 0);
    end
    exp_q.push_back('{exp: 6, zero: 0});
    din[0] = 8'h00;
    din[1] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(din_ready), 0);
      chk("stall_valid", int'(dout_valid), 1);
      chk("stall_data_out", int'(dout), 1);
      chk("stall_zero", int'(dout_zero), 0);
    end
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", int'(din_ready), 1);
    @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_queue_empty", exp_q.size(), 0);

    // Partial block discarded by reset.
    send_beat(8'h40, 8'h00, w);
    send_beat(8'h40, 8'h00, w);
    din_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midreset_valid", int'(dout_valid), 0);
    chk("midreset_data_out", int'(dout), 0);
    chk("midreset_in_ready", int'(din_ready), 1);
    @(posedge clk);
    #1;
    v.d = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01}; v.exp = 1; v.zero = 0;
    send_block(v, w);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Eight back-to-back beats: results four cycles apart, no input stalls.
    n = pop_cyc.size();
    v.d = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00}; v.exp = 2; v.zero = 0;
    send_block(v, w);
    chk("b2b_first_waits", w, 0);
    v.d = '{8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00}; v.exp = 7; v.zero = 0;
    send_block(v, w);
    chk("b2b_second_waits", w, 0);
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_outputs", pop_cyc.size() - n, 2);
    if (pop_cyc.size() - n == 2)
      chk("b2b_spacing", pop_cyc[n+1] - pop_cyc[n], NUM_BEATS);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
